line_memory: RTL

LINE_MEMORY -- requirements
Module: line_memory

---
 rtl/line_memory.sv | 112 +++++++++++
 1 files changed

// File: rtl/line_memory.sv
// rtl/line_memory.sv - 256-bit line memory answering each request with a single-cycle ack after a fixed latency
// Define LINE_MEMORY_RANGE_CHECK_EN to flag out-of-range line addresses on err_o instead of wrapping them.
module line_memory #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t             state;
    logic [7:0]         count;
    logic [IDX_W-1:0]   idx_q;
    logic               write_q;
    logic [255:0]       wdata_q;
    logic               range_err;
    logic               finish;
    logic               mem_we;
    logic               unused_addr;

    logic [255:0]       mem [DEPTH];

`ifdef LINE_MEMORY_RANGE_CHECK_EN
    logic               over_q;
    assign range_err   = over_q;
    assign unused_addr = ^addr_i[4:0];
`else
    assign range_err   = 1'b0;
    assign err_o       = 1'b0;
    assign unused_addr = ^{addr_i[4:0], addr_i[31:5+IDX_W]};
`endif

    // The edge that leaves BUSY is the single commit point for both reads and writes.
    assign finish = (state == BUSY) && (count == 8'd1);
    assign mem_we = finish && write_q && !range_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            count   <= '0;
            ack_o   <= 1'b0;
            data_o  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
            err_o   <= 1'b0;
            over_q  <= 1'b0;
`endif
        end else begin
            ack_o <= 1'b0;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
            err_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        idx_q   <= addr_i[5 +: IDX_W];
                        write_q <= write_i;
                        wdata_q <= data_i;
                        count   <= 8'(LATENCY - 1);
                        state   <= BUSY;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
                        over_q  <= ({5'd0, addr_i[31:5]} >= 32'(DEPTH));
`endif
                    end
                end
                BUSY: begin
                    count <= count - 8'd1;
                    if (finish) begin
                        state <= ACK;
                        ack_o <= 1'b1;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
                        err_o <= range_err;
`endif
                        if (range_err) begin
                            data_o <= '0;
                        end else if (write_q) begin
                            data_o <= wdata_q;
                        end else begin
                            data_o <= mem[idx_q];
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // No reset here: contents survive reset, and a reset clears state so an in-flight write never commits.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
